// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scanner: shift direction
// decoding and a counter width helper for the clock and shift dividers.
package led_matrix_pkg;

    typedef enum logic [1:0] {
        NONE,
        RIGHT,
        LEFT,
        HOLD
    } shift_dir_e;

    function automatic int ratio_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/led_matrix_scan_shift_ce_gen.sv
// Tick divider: emits a registered one-clock enable every RATIO clocks,
// the first one on clock RATIO after reset release.
module ce_gen
    import led_matrix_pkg::*;
#(
    parameter int RATIO = 48
) (
    input  logic clk,
    input  logic rst_n,
    output logic ce
);

    localparam int               CNT_W = ratio_width(RATIO);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        ce_d  = (cnt_q == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/led_matrix_scan_shift.sv
// Row-scanned LED matrix driver with a shiftable pattern register; shifts
// are requested by asynchronous buttons in either level-repeat or edge mode.
module led_matrix_scan_shift
    import led_matrix_pkg::*;
#(
    parameter int               CLK_REF    = 48_000_000,
    parameter int               CLK_CE     = 1_000_000,
    parameter int               ROWS       = 8,
    parameter int               COLS       = 8,
    parameter int               PAT_W      = 16,
    parameter int               SHIFT_STEP = 4,
    parameter int               SHIFT_DIV  = 100,
    parameter int               EDGE_MODE  = 0,
    parameter logic [PAT_W-1:0] INIT       = 16'h00F0
) (
    input  logic             clk,
    input  logic             btnCpuReset,
    input  logic             SHIFT_4B_R,
    input  logic             SHIFT_4B_L,
    input  logic             RE,
    output logic [ROWS-1:0]  STRING,
    output logic [COLS-1:0]  COLUMN,
    output logic [PAT_W-1:0] LED
);

    localparam int               RATIO    = CLK_REF / CLK_CE;
    localparam int               ROW_W    = ratio_width(ROWS);
    localparam int               DIV_W    = ratio_width(SHIFT_DIV);
    localparam int               IDX_W    = ratio_width(PAT_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);

    logic ce;

    ce_gen #(
        .RATIO(RATIO)
    ) u_ce_gen (
        .clk  (clk),
        .rst_n(btnCpuReset),
        .ce   (ce)
    );

    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [1:0]       prev_q, prev_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [PAT_W-1:0] led_q, led_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROWS-1:0]  string_q, string_d;
    logic [COLS-1:0]  column_q, column_d;

    logic             req_r, req_l, re_s, rise_r, rise_l, do_shift;
    logic [IDX_W-1:0] idx;
    shift_dir_e       dir;

    // Synchroniser bit order is {RE, left, right}; prev_q holds the last
    // synchronised requests for edge detection.
    always_comb begin
        sync1_d = {RE, SHIFT_4B_L, SHIFT_4B_R};
        sync2_d = sync1_q;
        prev_d  = sync2_q[1:0];
        req_r   = sync2_q[0];
        req_l   = sync2_q[1];
        re_s    = sync2_q[2];
        rise_r  = req_r & ~prev_q[0];
        rise_l  = req_l & ~prev_q[1];

        if (req_r && req_l) begin
            dir = HOLD;
        end else if (EDGE_MODE != 0) begin
            dir = rise_r ? RIGHT : (rise_l ? LEFT : NONE);
        end else begin
            dir = req_r ? RIGHT : (req_l ? LEFT : NONE);
        end
    end

    // Level mode only shifts after SHIFT_DIV ticks of one steady request.
    always_comb begin
        div_d    = div_q;
        do_shift = 1'b0;
        if (EDGE_MODE != 0) begin
            div_d    = '0;
            do_shift = (dir == RIGHT) || (dir == LEFT);
        end else if ((dir == RIGHT) || (dir == LEFT)) begin
            if (ce) begin
                if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    do_shift = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        end else begin
            div_d = '0;
        end

        led_d = led_q;
        if (do_shift) begin
            case (dir)
                RIGHT: led_d = re_s ? ((led_q >> SHIFT_STEP) | (led_q << (PAT_W - SHIFT_STEP)))
                                    : (led_q >> SHIFT_STEP);
                LEFT:  led_d = re_s ? ((led_q << SHIFT_STEP) | (led_q >> (PAT_W - SHIFT_STEP)))
                                    : (led_q << SHIFT_STEP);
                default: led_d = led_q;
            endcase
        end
    end

    // Row refresh reads the pattern as it stood on the tick, so a shift on
    // the same clock shows up whole on the following refresh.
    always_comb begin
        row_d    = row_q;
        string_d = string_q;
        column_d = column_q;
        idx      = '0;
        if (ce) begin
            string_d = ~(ROWS'(1) << row_q);
            for (int c = 0; c < COLS; c++) begin
                idx         = IDX_W'((int'(row_q) + c) % PAT_W);
                column_d[c] = ~led_q[idx];
            end
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            div_q    <= '0;
            led_q    <= INIT;
            row_q    <= '0;
            string_q <= '1;
            column_q <= '1;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            div_q    <= div_d;
            led_q    <= led_d;
            row_q    <= row_d;
            string_q <= string_d;
            column_q <= column_d;
        end
    end

    assign STRING = string_q;
    assign COLUMN = column_q;
    assign LED    = led_q;

endmodule

// File: doc/led_matrix_scan_shift.md
LED_MATRIX_SCAN_SHIFT -- requirements
Module: led_matrix_scan_shift

Interface
REQ-001 SHALL have parameter CLK_REF, default 48_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter CLK_CE, default 1_000_000, meaning scan tick frequency in Hz; CLK_REF/CLK_CE SHALL be an integer of at least 2.
REQ-003 SHALL have parameter ROWS, default 8, meaning number of matrix rows, range 2..16.
REQ-004 SHALL have parameter COLS, default 8, meaning number of matrix columns, range 2..16.
REQ-005 SHALL have parameter PAT_W, default 16, meaning pattern register width; PAT_W SHALL be at least COLS.
REQ-006 SHALL have parameter SHIFT_STEP, default 4, meaning bits moved per shift, range 1..PAT_W-1.
REQ-007 SHALL have parameter SHIFT_DIV, default 100, meaning scan ticks between level-mode shifts.
REQ-008 SHALL have parameter EDGE_MODE, default 0, meaning 0 = level-repeat shifting, 1 = one shift per rising edge.
REQ-009 SHALL have parameter INIT, default 16'h00F0 (PAT_W bits), meaning pattern reset value.
REQ-010 SHALL have port clk, input, 1, meaning single system clock; all logic on its rising edge.
REQ-011 SHALL have port btnCpuReset, input, 1, meaning reset, asynchronous and active-low.
REQ-012 SHALL have port SHIFT_4B_R, input, 1, meaning asynchronous shift-right request.
REQ-013 SHALL have port SHIFT_4B_L, input, 1, meaning asynchronous shift-left request.
REQ-014 SHALL have port RE, input, 1, meaning rotate enable: 1 = circular shift, 0 = zero fill.
REQ-015 SHALL have port STRING, output, ROWS, meaning active-low one-hot row select.
REQ-016 SHALL have port COLUMN, output, COLS, meaning active-low column data for the selected row.
REQ-017 SHALL have port LED, output, PAT_W, meaning current pattern register.

Function
REQ-018 SHALL synchronise SHIFT_4B_R, SHIFT_4B_L and RE with two flops each before use.
REQ-019 SHALL generate a one-clk ce pulse every CLK_REF/CLK_CE clocks, with the first pulse on clock N=CLK_REF/CLK_CE after reset release.
REQ-020 SHALL advance a row index r on each ce pulse (0,1,...,ROWS-1,0), wrapping at ROWS-1.
REQ-021 SHALL register STRING so that bit r is 0 and all other bits are 1, updated on the clock after the ce pulse.
REQ-022 SHALL register COLUMN[c] = ~LED[(r+c) mod PAT_W], updated on the same clock as STRING.
REQ-023 SHALL, when EDGE_MODE=0, count ce pulses while exactly one shift request is high, apply one shift when the count reaches SHIFT_DIV, then clear the count; the count SHALL clear whenever neither or both requests are high.
REQ-024 SHALL, when EDGE_MODE=1, apply exactly one shift on the clock after a synchronised rising edge of a request, independent of ce.
REQ-025 SHALL shift right as LED >> SHIFT_STEP, filling vacated MSBs with 0 when RE=0 or with the outgoing LSBs when RE=1.
REQ-026 SHALL shift left symmetrically, filling vacated LSBs with 0 when RE=0 or with the outgoing MSBs when RE=1.
REQ-027 SHALL hold LED unchanged when both requests are high simultaneously, including coincident edges in EDGE_MODE=1.
REQ-028 SHALL sample RE on the shift clock itself; an RE change takes effect on the next shift.
REQ-029 SHALL let a LED update become visible on COLUMN at the next ce-driven refresh, with no partial-row glitch.

Reset
REQ-030 SHALL, while btnCpuReset=0, force LED=INIT, STRING all ones, COLUMN all ones, row index 0, and all counters and synchroniser flops to 0.
REQ-031 SHALL abandon any in-progress shift count on reset; no shift SHALL occur within 2 clocks after reset release.

Structure
REQ-032 SHALL place a shift-direction enum (NONE, RIGHT, LEFT, HOLD) and a clog2-based ratio width function in package led_matrix_pkg.
REQ-033 SHALL instantiate one sub-module, ce_gen, as the parametrised tick divider.

Verification
REQ-034 SHALL verify reset: after release LED=16'h00F0, STRING=8'hFF; the first ce at clock 48 gives STRING=8'hFE and COLUMN=~{LED[7:0]}=8'h0F.
REQ-035 SHALL verify scan: 8 ce pulses give STRING 8'hFE..8'h7F, then wrap to 8'hFE.
REQ-036 SHALL verify level-mode right shift with RE=0: SHIFT_4B_R held for 100 ce pulses gives LED=16'h000F, and after a further 100 pulses LED=16'h0000.
REQ-037 SHALL verify rotation: starting from 16'h000F, RE=1 with a right shift gives LED=16'hF000, and a following left shift gives 16'h000F.
REQ-038 SHALL verify conflict: both requests high for 300 ce pulses leaves LED unchanged.
REQ-039 SHALL verify EDGE_MODE=1: three SHIFT_4B_L pulses of 1 µs each on 16'h00F0 with RE=0 give 16'h0F00, 16'hF000, 16'h0000; reset asserted mid-sequence returns LED to 16'h00F0.
